muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The clock port SHALL be: clk  input  1  clock; all state changes on the rising edge.
REQ-002 The reset port SHALL be: rst  input  1  reset, synchronous, active-low.
REQ-003 The start port SHALL be: start  input  1  launch the operation selected by op.
REQ-004 The op port SHALL be: op  input  2  operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 The a port SHALL be: a  input  32  multiplicand or dividend (rs).
REQ-006 The b port SHALL be: b  input  32  multiplier or divisor (rt).
REQ-007 The mt_hi and mt_lo ports SHALL be: mt_hi, mt_lo  input  1 each  MTHI/MTLO write strobes.
REQ-008 The wdata port SHALL be: wdata  input  32  MTHI/MTLO write data.
REQ-009 The hi and lo ports SHALL be: hi, lo  output  32 each  architectural HI/LO registers.
REQ-010 The busy port SHALL be: busy  output  1  operation in progress.
REQ-011 The done port SHALL be: done  output  1  one-cycle pulse; hi/lo hold the new result.
REQ-012 The div_by_zero port SHALL be: div_by_zero  output  1  qualifies done for DIV/DIVU with b==0.

Function
REQ-013 The FSM SHALL have states IDLE, PREP, ITER, FIX, DONE.
REQ-014 In IDLE or DONE, start=1 SHALL capture op, a and b into working registers and move to PREP; otherwise IDLE holds and DONE returns to IDLE.
REQ-015 In PREP, signed ops SHALL convert operands to absolute values and record result and remainder signs; the iteration counter SHALL clear to 0.
REQ-016 In PREP, DIV/DIVU with captured b==0 SHALL go directly to DONE; all other cases SHALL go to ITER.
REQ-017 ITER SHALL run exactly 32 cycles: multiply uses shift-add; divide uses restoring shift-subtract, one quotient bit per cycle; counter 31 SHALL move the FSM to FIX.
REQ-018 FIX SHALL apply sign correction and load hi/lo, then move to DONE.
  - MULT/MULTU: hi=product[63:32], lo=product[31:0].
  - DIV/DIVU: lo=quotient, hi=remainder.
REQ-019 Signed divide SHALL truncate toward zero; the remainder SHALL take the dividend's sign.
REQ-020 DIV 0x80000000/0xFFFFFFFF SHALL give lo=0x80000000, hi=0; no exception.
REQ-021 A divide by zero SHALL give hi=captured a and lo=0xFFFFFFFF, loaded on the PREP->DONE edge.
REQ-022 Outputs SHALL follow these rules:
  - busy=1 exactly in PREP, ITER and FIX.
  - done=1 exactly in DONE.
  - div_by_zero=1 only in a DONE entered via REQ-016.
REQ-023 hi/lo SHALL keep their prior values while busy and change only on FIX->DONE, PREP->DONE, or an MT write.
REQ-024 Latency, counting the start-sampling edge as edge 0:
  - done SHALL be high in the cycle after edge 34 for a normal op.
  - done SHALL be high in the cycle after edge 1 for a divide by zero.
REQ-025 mt_hi/mt_lo SHALL write wdata only in IDLE or DONE; when busy they SHALL be ignored.
REQ-026 mt_hi and mt_lo asserted together SHALL write both registers.
REQ-027 When start and an MT strobe occur in the same cycle, start SHALL win and the MT write SHALL be dropped.
REQ-028 start while busy SHALL be ignored; it SHALL NOT be queued.
REQ-029 Back-to-back: start in the DONE cycle SHALL launch the next op with no IDLE cycle.

Reset
REQ-030 rst=0 at a rising edge SHALL force:
  - state IDLE and counter 0;
  - hi=0, lo=0;
  - busy=0, done=0, div_by_zero=0;
  - working registers 0.
REQ-031 rst SHALL take priority over start and MT strobes, and SHALL abort an operation in progress without updating hi/lo to a partial result.

Verification
REQ-032 The bench SHALL cover the following scenarios:
  - MULTU a=0xFFFFFFFF b=2 -> done after edge 34, hi=0x00000001, lo=0xFFFFFFFE, busy high for edges 0-33.
  - MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
  - DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU a=100 b=0 -> done and div_by_zero high after edge 1, hi=0x00000064, lo=0xFFFFFFFF.
  - MTLO wdata=0x1234 in IDLE -> lo=0x1234; MTHI during busy -> hi unchanged; start at edge 5 of a running op -> ignored, result timing unchanged.
  - rst=0 at edge 10 of a MULT -> next cycle busy=0, done=0, hi=lo=0; a new op afterward completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / divide unit with HI/LO registers.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   start        launch the operation selected by op (ignored while busy)
//   op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a[31:0]      multiplicand / dividend
//   b[31:0]      multiplier / divisor
//   mt_hi/mt_lo  direct write strobes for HI/LO (honoured only when not busy)
//   wdata[31:0]  write data for mt_hi/mt_lo
//   hi/lo[31:0]  architectural HI/LO registers
//   busy         operation in progress (PREP, ITER, FIX)
//   done         one-cycle pulse, hi/lo hold the new result
//   div_by_zero  qualifies done for a divide with b == 0
//
// A normal operation takes PREP + 32 ITER cycles + FIX. Multiply and divide share
// one 64-bit working register pair {p_hi, p_lo}: for multiply it is the
// partial product with the multiplier shifting out of p_lo; for divide p_hi is
// the partial remainder and p_lo shifts dividend bits out and quotient bits in.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] m_q, m_d;          // |multiplicand| or |divisor|
    logic [31:0] p_hi_q, p_hi_d;
    logic [31:0] p_lo_q, p_lo_d;
    logic        neg_res_q, neg_res_d;  // product / quotient sign
    logic        neg_rem_q, neg_rem_d;  // remainder sign (dividend's sign)
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        is_div;
    logic        is_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mult_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] product;
    logic [63:0] product_neg;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign abs_a     = (is_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
    assign abs_b     = (is_signed && b_q[31]) ? (32'd0 - b_q) : b_q;

    // Shift-add step: add multiplicand when the multiplier LSB is set; the
    // 33-bit sum keeps the carry that shifts into the product on this step.
    assign mult_sum  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, m_q} : 33'd0);

    // Restoring divide step: bit 32 of the trial is the borrow, so a set bit
    // means the divisor did not fit and the shifted remainder is kept.
    assign div_shift = {p_hi_q, p_lo_q[31]};
    assign div_trial = div_shift - {1'b0, m_q};

    assign product     = {p_hi_q, p_lo_q};
    assign product_neg = 64'd0 - product;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        p_hi_d    = p_hi_q;
        p_lo_d    = p_lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // start wins over a simultaneous MT strobe
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = PREP;
                end else begin
                    if (mt_hi) hi_d = wdata;
                    if (mt_lo) lo_d = wdata;
                    state_d = IDLE;
                end
            end
            PREP: begin
                cnt_d     = 5'd0;
                neg_res_d = is_signed & (a_q[31] ^ b_q[31]);
                neg_rem_d = is_signed & a_q[31];
                p_hi_d    = 32'd0;
                if (is_div) begin
                    m_d    = abs_b;
                    p_lo_d = abs_a;
                end else begin
                    m_d    = abs_a;
                    p_lo_d = abs_b;
                end
                if (is_div && (b_q == 32'd0)) begin
                    hi_d    = a_q;
                    lo_d    = 32'hFFFF_FFFF;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                if (is_div) begin
                    if (!div_trial[32]) begin
                        p_hi_d = div_trial[31:0];
                        p_lo_d = {p_lo_q[30:0], 1'b1};
                    end else begin
                        p_hi_d = div_shift[31:0];
                        p_lo_d = {p_lo_q[30:0], 1'b0};
                    end
                end else begin
                    {p_hi_d, p_lo_d} = {mult_sum, p_lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                if (is_div) begin
                    lo_d = neg_res_q ? (32'd0 - p_lo_q) : p_lo_q;
                    hi_d = neg_rem_q ? (32'd0 - p_hi_q) : p_hi_q;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? product_neg : product;
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state.
        busy_d = (state_d == PREP) || (state_d == ITER) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_q      <= 2'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            m_q       <= 32'd0;
            p_hi_q    <= 32'd0;
            p_lo_q    <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            p_hi_q    <= p_hi_d;
            p_lo_q    <= p_lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes the expected result and
// completion cycle of each launched operation; an independent monitor pops
// and compares whenever done is seen.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mt_hi = 1'b0;
    logic        mt_lo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .mt_hi       (mt_hi),
        .mt_lo       (mt_lo),
        .wdata       (wdata),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    int     txn = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        longint      cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] m_hi = 32'd0;   // expected architectural HI
    logic [31:0] m_lo = 32'd0;   // expected architectural LO

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference results from plain integer arithmetic.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] rh, output logic [31:0] rl, output logic rz);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        rz = 1'b0;
        rh = 32'd0;
        rl = 32'd0;
        case (o)
            2'b00: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p  = sx * sy;
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b01: begin
                p  = {32'd0, x} * {32'd0, y};
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b10: begin
                if (y == 32'd0) begin
                    rh = x; rl = 32'hFFFF_FFFF; rz = 1'b1;
                end else begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    q  = sx / sy;
                    r  = sx % sy;
                    p  = q;
                    rl = p[31:0];
                    p  = r;
                    rh = p[31:0];
                end
            end
            default: begin
                if (y == 32'd0) begin
                    rh = x; rl = 32'hFFFF_FFFF; rz = 1'b1;
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result_hi", hi, mon_e.hi);
                chk("result_lo", lo, mon_e.lo);
                chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                txn++;
                $display("txn %0d: hi=%h lo=%h dbz=%0b cycle=%0d", txn, hi, lo, div_by_zero, cyc);
            end
        end
    end

    // Launch one operation from a negedge and follow it to its done cycle.
    // mt_at / start_at inject an MTHI or a stray start during the busy window.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int mt_at, input int start_at, input bit mt_with_start);
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        int          lat;
        exp_t        e;
        ref_model(o, x, y, eh, el, ez);
        lat   = ez ? 1 : 34;
        e.hi  = eh;
        e.lo  = el;
        e.dbz = ez;
        e.cyc = cyc + longint'(lat) + 1;
        sb.push_back(e);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (mt_with_start) begin
            mt_hi = 1'b1;
            mt_lo = 1'b1;
            wdata = $urandom;
        end
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            start = 1'b0;
            mt_hi = 1'b0;
            mt_lo = 1'b0;
            a     = $urandom;
            b     = $urandom;
            op    = 2'($urandom_range(3, 0));
            if (k < lat) begin
                chk("busy_high", 32'(busy), 32'd1);
                chk("done_low", 32'(done), 32'd0);
                chk("hold_hi", hi, m_hi);
                chk("hold_lo", lo, m_lo);
                if (k == mt_at) begin
                    mt_hi = 1'b1;
                    wdata = $urandom;
                end
                if (k == start_at) start = 1'b1;
            end else begin
                chk("busy_low_at_done", 32'(busy), 32'd0);
            end
        end
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
        mt_hi = wh;
        mt_lo = wl;
        wdata = d;
        @(negedge clk);
        mt_hi = 1'b0;
        mt_lo = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
        chk("mt_hi_value", hi, m_hi);
        chk("mt_lo_value", lo, m_lo);
    endtask

    // Start an op, pull rst low so it is sampled at edge 10, check the abort.
    task automatic abort_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst   = 1'b0;
        mt_hi = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mt_hi = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(7, 0))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(20, 0));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        // Reset with start and MT strobes asserted: reset must win.
        start = 1'b1;
        mt_hi = 1'b1;
        mt_lo = 1'b1;
        wdata = 32'hAAAA_5555;
        repeat (3) @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        start = 1'b0;
        mt_hi = 1'b0;
        mt_lo = 1'b0;
        rst   = 1'b1;
        @(negedge clk);

        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, -1, -1, 1'b0);
        @(negedge clk);
        mt_write(1'b0, 1'b1, 32'h0000_1234);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 10, 4, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
        @(negedge clk);
        run_op(2'b11, 32'd100, 32'd0, -1, -1, 1'b1);
        run_op(2'b11, 32'd100, 32'd7, -1, -1, 1'b0);
        @(negedge clk);
        abort_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op(2'b00, 32'h1234_5678, 32'hFFFF_FF00, -1, -1, 1'b0);
        @(negedge clk);
        mt_write(1'b1, 1'b1, 32'hCAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            run_op(2'($urandom_range(3, 0)), ra, rb,
                   ($urandom_range(3, 0) == 0) ? 20 : -1,
                   ($urandom_range(3, 0) == 0) ? 4 : -1,
                   1'($urandom_range(1, 0)));
            if ($urandom_range(2, 0) == 0) begin
                @(negedge clk);
                mt_write(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
